// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: program counter, req/ack fetch FSM towards instruction memory and IF/ID register.
// Optional feature: define MISALIGN_TRAP_EN to flag redirects to non-word-aligned targets (sticky misalign_err).
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        npc_sel,
    input  logic [31:0] npc_in,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_WAIT  = 2'b01,
        ST_HOLD  = 2'b10,
        ST_DRAIN = 2'b11
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] pending_r;
    logic [31:0] skid_r;
    logic        imem_req_r;
    logic [31:0] if_instr_r;
    logic [31:0] if_pc_plus4_r;
    logic        if_valid_r;

    logic [31:0] npc_aligned_s;
    logic [31:0] pc_plus4_s;
    logic        deliver_s;
    logic [31:0] deliver_data_s;

    // Low target bits are never used for the PC; the fetch address stays word aligned.
    assign npc_aligned_s = {npc_in[31:2], 2'b00};
    assign pc_plus4_s    = pc_r + 32'd4;

    // Decide whether a fresh instruction reaches IF/ID on this edge (memory word or skid word).
    always_comb begin
        deliver_s      = 1'b0;
        deliver_data_s = 32'h0000_0000;
        case (state_r)
            ST_WAIT: begin
                if (imem_ack && !npc_sel && !stall) begin
                    deliver_s      = 1'b1;
                    deliver_data_s = imem_rdata;
                end else begin
                    deliver_s      = 1'b0;
                    deliver_data_s = 32'h0000_0000;
                end
            end
            ST_HOLD: begin
                if (!npc_sel && !stall) begin
                    deliver_s      = 1'b1;
                    deliver_data_s = skid_r;
                end else begin
                    deliver_s      = 1'b0;
                    deliver_data_s = 32'h0000_0000;
                end
            end
            default: begin
                deliver_s      = 1'b0;
                deliver_data_s = 32'h0000_0000;
            end
        endcase
    end

    // Fetch FSM: owns PC, pending redirect target, skid buffer and the registered request.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r    <= ST_FETCH;
            pc_r       <= RESET_PC;
            pending_r  <= 32'h0000_0000;
            skid_r     <= 32'h0000_0000;
            imem_req_r <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (npc_sel) begin
                        pc_r <= npc_aligned_s;
                    end
                    state_r    <= ST_WAIT;
                    imem_req_r <= 1'b1;
                end
                ST_WAIT: begin
                    if (imem_ack) begin
                        imem_req_r <= 1'b0;
                        if (npc_sel) begin
                            pc_r    <= npc_aligned_s;
                            state_r <= ST_FETCH;
                        end else if (stall) begin
                            skid_r  <= imem_rdata;
                            state_r <= ST_HOLD;
                        end else begin
                            pc_r    <= pc_plus4_s;
                            state_r <= ST_FETCH;
                        end
                    end else if (npc_sel) begin
                        // The access cannot be cancelled; remember where to go once it retires.
                        pending_r  <= npc_aligned_s;
                        state_r    <= ST_DRAIN;
                        imem_req_r <= 1'b0;
                    end else begin
                        state_r    <= ST_WAIT;
                        imem_req_r <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    imem_req_r <= 1'b0;
                    if (npc_sel) begin
                        pc_r    <= npc_aligned_s;
                        state_r <= ST_FETCH;
                    end else if (!stall) begin
                        pc_r    <= pc_plus4_s;
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    imem_req_r <= 1'b0;
                    if (imem_ack) begin
                        pc_r    <= npc_sel ? npc_aligned_s : pending_r;
                        state_r <= ST_FETCH;
                    end else if (npc_sel) begin
                        pending_r <= npc_aligned_s;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r    <= ST_FETCH;
                    imem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID register: flush beats stall, stall holds, otherwise load or insert a bubble.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            if_instr_r    <= 32'h0000_0000;
            if_pc_plus4_r <= 32'h0000_0000;
            if_valid_r    <= 1'b0;
        end else if (npc_sel) begin
            if_valid_r <= 1'b0;
        end else if (deliver_s) begin
            if_instr_r    <= deliver_data_s;
            if_pc_plus4_r <= pc_plus4_s;
            if_valid_r    <= 1'b1;
        end else if (stall) begin
            if_valid_r <= if_valid_r;
        end else begin
            if_valid_r <= 1'b0;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_r;

    // Sticky trap flag for any redirect whose target is not word aligned.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            misalign_r <= 1'b0;
        end else if (npc_sel && (npc_in[1:0] != 2'b00)) begin
            misalign_r <= 1'b1;
        end else begin
            misalign_r <= misalign_r;
        end
    end

    assign misalign_err = misalign_r;
`else
    logic unused_npc_lsb_s;
    assign unused_npc_lsb_s = ^npc_in[1:0];
    assign misalign_err     = 1'b0;
`endif

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign if_instr    = if_instr_r;
    assign if_pc_plus4 = if_pc_plus4_r;
    assign if_valid    = if_valid_r;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: flag-based transaction model checked every cycle plus hand-computed directed checks.
module tb_pc_fetch_stage;

    localparam logic [31:0] RPC = 32'h0040_0000;
`ifdef MISALIGN_TRAP_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        npc_sel;
    logic [31:0] npc_in;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;
    logic        if_valid;
    logic        misalign_err;
    logic        ack_tie;
    logic        ack_drv;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic [31:0] w_instr;
    logic [31:0] w_pc4;
    logic        w_valid;
    logic        w_err;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_ack   = ack_tie ? imem_req : ack_drv;
    assign imem_rdata = mem_word(imem_addr);
    assign w_rdata    = mem_word(w_addr);

    pc_fetch_stage #(.RESET_PC(RPC)) dut (
        .Clk(Clk), .Reset(Reset), .npc_sel(npc_sel), .npc_in(npc_in), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_instr(if_instr), .if_pc_plus4(if_pc_plus4), .if_valid(if_valid), .misalign_err(misalign_err)
    );

    pc_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .Clk(Clk), .Reset(Reset), .npc_sel(1'b0), .npc_in(32'h0000_0000), .stall(1'b0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_req), .imem_rdata(w_rdata),
        .if_instr(w_instr), .if_pc_plus4(w_pc4), .if_valid(w_valid), .misalign_err(w_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Abstract fetch model: busy = access outstanding, drop = its data is unwanted, held = word parked.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic [31:0] skid;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        busy;
        logic        drop;
        logic        held;
        logic        valid;
        logic        err;
    } model_t;

    localparam model_t M_RESET = '{pc: RPC, default: '0};

    model_t m;

    function automatic model_t model_step(input model_t s, input logic sel, input logic [31:0] npc,
                                          input logic stl, input logic ack, input logic [31:0] rd);
        model_t      n   = s;
        logic [31:0] tgt = {npc[31:2], 2'b00};
        logic        got = 1'b0;
        logic [31:0] w   = 32'h0;
        if (!s.busy && !s.held) begin
            n.busy = 1'b1;
            n.drop = 1'b0;
            if (sel) n.pc = tgt;
        end else if (s.held) begin
            if (sel) begin
                n.held = 1'b0;
                n.pc   = tgt;
            end else if (!stl) begin
                n.held = 1'b0;
                got    = 1'b1;
                w      = s.skid;
                n.pc   = s.pc + 32'd4;
            end
        end else if (!s.drop) begin
            if (ack) begin
                n.busy = 1'b0;
                if (sel) n.pc = tgt;
                else if (stl) begin
                    n.held = 1'b1;
                    n.skid = rd;
                end else begin
                    got  = 1'b1;
                    w    = rd;
                    n.pc = s.pc + 32'd4;
                end
            end else if (sel) begin
                n.drop   = 1'b1;
                n.target = tgt;
            end
        end else begin
            if (ack) begin
                n.busy = 1'b0;
                n.drop = 1'b0;
                n.pc   = sel ? tgt : s.target;
            end else if (sel) begin
                n.target = tgt;
            end
        end
        if (sel) n.valid = 1'b0;
        else if (got) begin
            n.valid = 1'b1;
            n.instr = w;
            n.pc4   = s.pc + 32'd4;
        end else if (!stl) n.valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (sel && (npc[1:0] != 2'b00)) n.err = 1'b1;
`endif
        return n;
    endfunction

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) m <= M_RESET;
        else        m <= model_step(m, npc_sel, npc_in, stall, imem_ack, imem_rdata);
    end

    always @(negedge Clk) begin
        chk("req", 32'(imem_req), 32'(m.busy && !m.drop));
        chk("addr", imem_addr, m.pc);
        chk("valid", 32'(if_valid), 32'(m.valid));
        chk("err", 32'(misalign_err), 32'(m.err));
        if (m.valid) begin
            chk("instr", if_instr, m.instr);
            chk("pc4", if_pc_plus4, m.pc4);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    typedef struct packed {
        logic        sel;
        logic [31:0] npc;
        logic        stl;
        logic        ack;
    } vec_t;

    vec_t vtab[16];

    initial begin
        vtab = '{
            '{1'b0, 32'h0000_0000, 1'b0, 1'b0}, '{1'b0, 32'h0000_0000, 1'b0, 1'b0},
            '{1'b0, 32'h0000_0000, 1'b0, 1'b1}, '{1'b0, 32'h0000_0000, 1'b0, 1'b0},
            '{1'b0, 32'h0000_0000, 1'b1, 1'b1}, '{1'b0, 32'h0000_0000, 1'b1, 1'b0},
            '{1'b1, 32'h0000_0300, 1'b1, 1'b0}, '{1'b0, 32'h0000_0000, 1'b0, 1'b0},
            '{1'b0, 32'h0000_0000, 1'b0, 1'b0}, '{1'b1, 32'h0000_0404, 1'b0, 1'b0},
            '{1'b1, 32'h0000_0508, 1'b0, 1'b0}, '{1'b1, 32'h0000_050C, 1'b0, 1'b1},
            '{1'b0, 32'h0000_0000, 1'b0, 1'b0}, '{1'b0, 32'h0000_0000, 1'b1, 1'b0},
            '{1'b0, 32'h0000_0000, 1'b0, 1'b1}, '{1'b1, 32'h0000_0600, 1'b0, 1'b1}
        };
        Reset = 1'b1; npc_sel = 1'b0; npc_in = 32'h0; stall = 1'b0;
        ack_tie = 1'b1; ack_drv = 1'b0;
        #1 Reset = 1'b0;
        #10;
        chk("rst_addr", imem_addr, RPC);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc4", if_pc_plus4, 32'd0);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        Reset = 1'b1;

        // Zero-wait memory: one instruction every second cycle.
        step(1);
        chk("t1_req", 32'(imem_req), 32'd1);
        chk("t1_addr0", imem_addr, 32'h0040_0000);
        step(1);
        chk("t1_valid", 32'(if_valid), 32'd1);
        chk("t1_pc4", if_pc_plus4, 32'h0040_0004);
        chk("t1_instr", if_instr, mem_word(32'h0040_0000));
        chk("wrap_valid", 32'(w_valid), 32'd1);
        chk("wrap_pc4", w_pc4, 32'h0000_0000);
        chk("wrap_addr1", w_addr, 32'h0000_0000);
        step(1);
        chk("t1_addr1", imem_addr, 32'h0040_0004);
        chk("t1_bubble", 32'(if_valid), 32'd0);
        step(1);
        chk("t1_pc4b", if_pc_plus4, 32'h0040_0008);

        // Stall across the ack edge parks the word; release loads it and advances once.
        stall = 1'b1;
        step(2);
        repeat (3) begin
            chk("t2_req_hold", 32'(imem_req), 32'd0);
            chk("t2_valid_hold", 32'(if_valid), 32'd1);
            chk("t2_pc4_hold", if_pc_plus4, 32'h0040_0008);
            chk("t2_addr_hold", imem_addr, 32'h0040_0008);
            step(1);
        end
        stall = 1'b0;
        step(1);
        chk("t2_release_pc4", if_pc_plus4, 32'h0040_000C);
        chk("t2_release_instr", if_instr, mem_word(32'h0040_0008));
        step(1);
        chk("t2_next_addr", imem_addr, 32'h0040_000C);

        // Slow memory, redirect while waiting: returned word is dropped.
        ack_tie = 1'b0; ack_drv = 1'b0;
        step(2);
        npc_sel = 1'b1; npc_in = 32'h0000_0100;
        step(1);
        chk("t3_drain_req", 32'(imem_req), 32'd0);
        npc_sel = 1'b0;
        step(1);
        ack_drv = 1'b1;
        step(1);
        chk("t3_valid", 32'(if_valid), 32'd0);
        ack_drv = 1'b0; ack_tie = 1'b1;
        step(1);
        chk("t3_next_addr", imem_addr, 32'h0000_0100);
        npc_sel = 1'b1; npc_in = 32'h0000_0200;
        step(1);
        chk("t3_same_edge_addr", imem_addr, 32'h0000_0200);
        npc_sel = 1'b0;

        // Misaligned redirect target.
        npc_sel = 1'b1; npc_in = 32'h0000_0103;
        step(1);
        chk("t6_addr", imem_addr, 32'h0000_0100);
        chk("t6_err", 32'(misalign_err), 32'(EXP_ERR));
        npc_sel = 1'b0;
        step(2);
        chk("t6_pc4", if_pc_plus4, 32'h0000_0104);
        chk("t6_err_sticky", 32'(misalign_err), 32'(EXP_ERR));

        ack_tie = 1'b0;
        for (int i = 0; i < 16; i++) begin
            npc_sel = vtab[i].sel; npc_in = vtab[i].npc;
            stall = vtab[i].stl; ack_drv = vtab[i].ack;
            step(1);
        end
        npc_sel = 1'b0; stall = 1'b0; ack_drv = 1'b0; ack_tie = 1'b1;

        // Asynchronous reset in the middle of a WAIT.
        begin
            int n = 0;
            while (!imem_req && n < 20) begin
                step(1);
                n++;
            end
        end
        chk("t5_wait_req", 32'(imem_req), 32'd1);
        #2 Reset = 1'b0;
        #1;
        chk("t5_req", 32'(imem_req), 32'd0);
        chk("t5_valid", 32'(if_valid), 32'd0);
        chk("t5_addr", imem_addr, RPC);
        chk("t5_err", 32'(misalign_err), 32'd0);
        #5 Reset = 1'b1;
        step(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
